// File: rtl/ex_mul_unit.sv
// Execute-stage radix-2 shift-add multiplier, signed/unsigned, stalls the pipe via busy.
// One multiplier bit retires per cycle; sign is applied to the magnitude product at the end.
//
// state | meaning
// IDLE  | waiting for a MUL opcode in ID/EX
// RUN   | WIDTH shift-add iterations on the magnitudes
// DONE  | one-cycle result pulse, product registers load

module ex_mul_unit #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] MUL_OP = 5'b10010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic             mul_signed,
  input  logic             high,
  input  logic             low,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [1:0]         sel_q;
  logic [WIDTH-1:0]   result_q;

  logic               start;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   p_sel;

  assign start = (state == S_IDLE) && (opcode == MUL_OP) && !flush;
  assign busy  = (start || (state == S_RUN)) && !flush;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign mag1 = (mul_signed && rd1[WIDTH-1]) ? (~rd1 + ONE_W) : rd1;
  assign mag2 = (mul_signed && rd2[WIDTH-1]) ? (~rd2 + ONE_W) : rd2;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign p   = neg ? (~acc + ONE_2W) : acc;

  // high wins over low; neither selects the lower half
  always_comb begin
    p_sel = p[WIDTH-1:0];
    case (sel_q)
      2'b10, 2'b11: p_sel = p[2*WIDTH-1:WIDTH];
      default:      p_sel = p[WIDTH-1:0];
    endcase
  end

  assign result_valid = (state == S_DONE) && !flush;
  assign result       = (state == S_DONE) ? p_sel : result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      sel_q    <= 2'b00;
      result_q <= '0;
      prod_hi  <= '0;
      prod_lo  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= mag1;
            acc   <= {{WIDTH{1'b0}}, mag2};
            neg   <= mul_signed & (rd1[WIDTH-1] ^ rd2[WIDTH-1]);
            sel_q <= {high, low};
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= {sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          prod_hi  <= p[2*WIDTH-1:WIDTH];
          prod_lo  <= p[WIDTH-1:0];
          result_q <= p_sel;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_mul_unit.md
Name: ex_mul_unit

Overview:
- Execute-stage iterative multiplier. Consumes the opcode, operand and high/low select outputs of the ID/EX pipeline register.
- While a multiply is in progress it asserts busy. Busy drives the stall input of the ID/EX register and the upstream stages, so the MUL instruction stays in EX until its result is ready.
- Uses a radix-2 shift-add datapath: one operand bit per cycle, signed or unsigned, 64-bit product.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- MUL_OP, 5'b10010, opcode value that starts a multiply.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  kill any in-flight multiply (same flush that clears ID/EX)
- opcode  input  5  opcode_out of ID/EX
- rd1  input  WIDTH  multiplicand (rd1_bypass_out, post-forwarding)
- rd2  input  WIDTH  multiplier (rd2_bypass_out, post-forwarding)
- mul_signed  input  1  1 = two's-complement operands, 0 = unsigned
- high  input  1  select upper product half for result
- low  input  1  select lower product half for result
- busy  output  1  stall request to ID/EX and upstream
- result_valid  output  1  one-cycle pulse, result valid for writeback
- result  output  WIDTH  selected product half
- prod_hi  output  WIDTH  upper half of last completed product
- prod_lo  output  WIDTH  lower half of last completed product

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter, accumulator and operand registers cleared. busy=0, result_valid=0, result=0, prod_hi=0, prod_lo=0.
- start = (state==IDLE) && (opcode==MUL_OP) && !flush.
- busy is combinational: (start || state==RUN) && !flush. It rises in the same cycle the MUL sits in ID/EX.
- State IDLE, on start at the clock edge:
  - Latch |rd1| and |rd2| as magnitudes. Absolute value is used only when mul_signed=1 and the operand MSB=1. -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  - Latch neg = mul_signed & (rd1[MSB]^rd2[MSB]), plus high and low.
  - Clear the 2*WIDTH accumulator (upper half = partial sum, lower half = multiplier). Counter=0. Go to RUN.
- State RUN, each cycle:
  - If accumulator LSB=1, add the multiplicand to the upper half with WIDTH+1-bit carry.
  - Shift the whole {carry, accumulator} right by 1. Counter++.
  - When the counter reaches WIDTH-1 (the WIDTH-th iteration), go to DONE.
- State DONE, one cycle:
  - busy=0, result_valid=1. P = neg ? two's-complement negation of the accumulator (mod 2^(2*WIDTH)) : accumulator.
  - result = high ? P[2W-1:W] : P[W-1:0]. high takes precedence; neither set selects the lower half.
  - prod_hi/prod_lo load P at this edge. Next state is IDLE unconditionally.
  - Because busy=0 in DONE, ID/EX advances at this edge, so a following MUL starts from IDLE on the next cycle (no self-retrigger).
- Latency: accept cycle c0. RUN spans c1..cWIDTH. DONE/result_valid at c(WIDTH+1). busy high for WIDTH+1 cycles (c0..cWIDTH).
- result holds its last value outside DONE. result_valid is 0 in IDLE and RUN.
- Flush has priority over everything:
  - In any state, flush=1 forces busy=0 combinationally and state=IDLE at the edge.
  - No result_valid; prod_hi/prod_lo unchanged.
  - Flush in DONE suppresses result_valid and the prod update.
- Operands are not re-sampled during RUN; changes on rd1/rd2/high/low after c0 are ignored.
- Non-MUL opcodes in IDLE: no effect, busy=0.
- Reset mid-operation: immediate return to reset values; no partial result is exposed.

Test Plan:
- Unsigned 3*5, low=1, held in ID/EX: busy=1 for 33 cycles; result_valid at cycle 33 with result=15; prod_hi=0, prod_lo=15.
- Signed -3*7: low=1 gives result=0xFFFFFFEB; repeated with high=1 gives result=0xFFFFFFFF. Signed 0x80000000*0x80000000 with high=1 gives 0x40000000.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF: high=1 gives 0xFFFFFFFE; prod_lo=0x00000001.
- Flush asserted at cycle 10 of RUN: busy=0 in that cycle; state IDLE next; no result_valid pulse; prod_hi/prod_lo retain the prior product.
- Back-to-back MULs (2*3 then 4*5): first result_valid=6 at cycle 33; second busy rises at cycle 34; result_valid=20 at cycle 67; no spurious third start.
- rst_n pulsed low mid-RUN: all outputs 0 immediately; after release, IDLE with busy=0 until the next MUL_OP.
